// File: rtl/control_unit_if.sv
// control_unit_if: instruction fields and control strobes between the multicycle
// datapath (master) and its control FSM (slave).
interface control_unit_if;
    logic [6:0] Op;
    logic [2:0] Funct3;
    logic [6:0] Funct7;
    logic       Zero;
    logic       PCWrite, RegWrite, MemWrite, IRWrite, ADRSrc;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ALUControl, ImmSrc;
    logic       Illegal_o, Instr_Done;
    modport master (
        output Op, Funct3, Funct7, Zero,
        input  PCWrite, RegWrite, MemWrite, IRWrite, ADRSrc, ResultSrc, ALUSrcA, ALUSrcB,
        input  ALUControl, ImmSrc, Illegal_o, Instr_Done
    );
    modport slave (
        input  Op, Funct3, Funct7, Zero,
        output PCWrite, RegWrite, MemWrite, IRWrite, ADRSrc, ResultSrc, ALUSrcA, ALUSrcB,
        output ALUControl, ImmSrc, Illegal_o, Instr_Done
    );
endinterface

// File: rtl/control_unit.sv
// control_unit: multicycle RV32I Moore control FSM with a sticky illegal-instruction flag.
// Define UTYPE_INSTR_EN to decode lui/auipc through the UTYPE state.
module control_unit (
    input logic           clk,
    input logic           reset,
    control_unit_if.slave bus
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI,
        ALUWB, BRANCH, JAL, JALR, JALRLINK, UTYPE
    } state_t;
    localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
                           OP_I = 7'b0010011, OP_B = 7'b1100011, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;
    state_t     r_state, w_next;
    logic       r_illegal, w_illegal, w_shift, w_bad_br, w_take, w_unused;
    logic       w_pcw, w_rw, w_mw, w_irw, w_done;
    logic [2:0] w_alu_f3;
    assign w_unused = ^{bus.Funct7[6], bus.Funct7[4:0]};
    assign w_shift  = bus.Funct3[1:0] == 2'b01;
    assign w_bad_br = bus.Funct3[2:1] == 2'b01;
    // beq/bge/bgeu take on Zero, the others on !Zero
    assign w_take   = bus.Zero ^ bus.Funct3[0] ^ bus.Funct3[2];
    assign w_alu_f3 = bus.Funct3 == 3'b010 ? 3'b101 :
                      bus.Funct3 == 3'b011 ? 3'b110 :
                      bus.Funct3 == 3'b100 ? 3'b100 :
                      bus.Funct3 == 3'b110 ? 3'b011 :
                      bus.Funct3 == 3'b111 ? 3'b010 : 3'b000;
    assign bus.ImmSrc = bus.Op == OP_SW ? 3'b001 :
                        bus.Op == OP_B ? 3'b010 :
                        bus.Op == OP_JAL ? 3'b011 :
                        (bus.Op == OP_LUI || bus.Op == OP_AUIPC) ? 3'b100 : 3'b000;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= FETCH;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_illegal <= r_illegal | w_illegal;
        end
    end
    always_comb begin
        w_next    = FETCH;
        w_illegal = 1'b0;
        case (r_state)
            FETCH:    w_next = DECODE;
            DECODE: begin
                case (bus.Op)
                    OP_LW, OP_SW: w_next = MEMADR;
                    OP_R:         w_next = EXECR;
                    OP_I:         w_next = EXECI;
                    OP_B:         w_next = BRANCH;
                    OP_JAL:       w_next = JAL;
                    OP_JALR:      w_next = JALR;
`ifdef UTYPE_INSTR_EN
                    OP_LUI, OP_AUIPC: w_next = UTYPE;
`endif
                    default:      w_illegal = 1'b1;
                endcase
            end
            MEMADR:   w_next = bus.Op == OP_LW ? MEMREAD : MEMWRITE;
            MEMREAD:  w_next = MEMWB;
            EXECR, EXECI: begin
                w_next    = w_shift ? FETCH : ALUWB;
                w_illegal = w_shift;
            end
            BRANCH:   w_illegal = w_bad_br;
            JAL:      w_next = ALUWB;
            JALR:     w_next = JALRLINK;
            JALRLINK: w_next = ALUWB;
`ifdef UTYPE_INSTR_EN
            UTYPE:    w_next = ALUWB;
`endif
            default:  w_next = FETCH;
        endcase
    end
    always_comb begin
        {w_pcw, w_rw, w_mw, w_irw, w_done, bus.ADRSrc} = '0;
        bus.ResultSrc  = 2'd0;
        bus.ALUSrcA    = 2'd0;
        bus.ALUSrcB    = 2'd0;
        bus.ALUControl = 3'b000;
        case (r_state)
            FETCH: begin
                w_irw         = 1'b1;
                w_pcw         = 1'b1;
                bus.ALUSrcB   = 2'd2;
                bus.ResultSrc = 2'd2;
            end
            DECODE: begin
                bus.ALUSrcA = 2'd1;
                bus.ALUSrcB = 2'd1;
            end
            MEMADR, JALR: begin
                bus.ALUSrcA = 2'd2;
                bus.ALUSrcB = 2'd1;
            end
            MEMREAD:  bus.ADRSrc = 1'b1;
            MEMWB: begin
                bus.ResultSrc = 2'd1;
                w_rw          = 1'b1;
                w_done        = 1'b1;
            end
            MEMWRITE: begin
                bus.ADRSrc = 1'b1;
                w_mw       = 1'b1;
                w_done     = 1'b1;
            end
            EXECR: begin
                bus.ALUSrcA    = 2'd2;
                bus.ALUControl = (bus.Funct3 == 3'b000 && bus.Funct7[5]) ? 3'b001 : w_alu_f3;
            end
            EXECI: begin
                bus.ALUSrcA    = 2'd2;
                bus.ALUSrcB    = 2'd1;
                bus.ALUControl = w_alu_f3;
            end
            ALUWB: begin
                w_rw   = 1'b1;
                w_done = 1'b1;
            end
            BRANCH: begin
                bus.ALUSrcA    = 2'd2;
                bus.ALUControl = bus.Funct3[2] ? (bus.Funct3[1] ? 3'b110 : 3'b101) : 3'b001;
                w_pcw          = w_take && !w_bad_br;
                w_done         = !w_bad_br;
            end
            JAL, JALRLINK: begin
                bus.ALUSrcA = 2'd1;
                bus.ALUSrcB = 2'd2;
                w_pcw       = 1'b1;
            end
`ifdef UTYPE_INSTR_EN
            UTYPE: begin
                bus.ALUSrcB    = 2'd1;
                bus.ALUSrcA    = bus.Op == OP_AUIPC ? 2'd1 : 2'd0;
                bus.ALUControl = bus.Op == OP_AUIPC ? 3'b000 : 3'b111;
            end
`endif
            default: ;
        endcase
    end
    // strobes are held low for the whole reset pulse, independent of state
    assign bus.PCWrite    = w_pcw & ~reset;
    assign bus.RegWrite   = w_rw & ~reset;
    assign bus.MemWrite   = w_mw & ~reset;
    assign bus.IRWrite    = w_irw & ~reset;
    assign bus.Instr_Done = w_done & ~reset;
    assign bus.Illegal_o  = r_illegal;
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: per-instruction cycle-sequence model of the control unit
// compared against the DUT every cycle, plus literal spot checks.
module tb_control_unit;
    typedef struct packed {
        logic       pcw, rw, mw, irw;
        logic [1:0] rsrc, asa, asb;
        logic       adr;
        logic [2:0] aluc, imm;
        logic       ill, done;
    } cyc_t;
    localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011,
                           XOR_ = 3'b100, SLT = 3'b101, SLTU = 3'b110, PASS = 3'b111;
    logic  clk = 1'b0;
    logic  reset = 1'b1;
    int    checks = 0;
    int    failures = 0;
    cyc_t  q[$];
    cyc_t  obs[$];
    logic [2:0] cur_imm;
    logic  m_ill = 1'b0;
    string cur_name = "reset";
    control_unit_if bus();
    control_unit dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
    always @(negedge clk) begin
        if (q.size() > 0) begin
            cyc_t e, a;
            e = q.pop_front();
            a = '{bus.PCWrite, bus.RegWrite, bus.MemWrite, bus.IRWrite, bus.ResultSrc,
                  bus.ALUSrcA, bus.ALUSrcB, bus.ADRSrc, bus.ALUControl, bus.ImmSrc,
                  bus.Illegal_o, bus.Instr_Done};
            obs.push_back(a);
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL %s cycle %0d got=%h expected=%h", cur_name, obs.size() - 1, a, e);
            end
        end
    end
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
        end
    endtask
    function automatic cyc_t mk(input logic pcw, rw, mw, irw, input logic [1:0] rs, sa, sb,
                                input logic adr, input logic [2:0] alu, input logic dn);
        mk = '{pcw, rw, mw, irw, rs, sa, sb, adr, alu, cur_imm, m_ill, dn};
    endfunction
    function automatic logic [2:0] imm_of(input logic [6:0] op);
        case (op)
            7'b0100011: imm_of = 3'b001;
            7'b1100011: imm_of = 3'b010;
            7'b1101111: imm_of = 3'b011;
            7'b0110111, 7'b0010111: imm_of = 3'b100;
            default: imm_of = 3'b000;
        endcase
    endfunction
    function automatic logic [2:0] alu_of(input logic [2:0] f3);
        case (f3)
            3'd2: alu_of = SLT;
            3'd3: alu_of = SLTU;
            3'd4: alu_of = XOR_;
            3'd6: alu_of = OR_;
            3'd7: alu_of = AND_;
            default: alu_of = ADD;
        endcase
    endfunction
    // branch semantics: slt/sltu leave a nonzero result when "less than" holds
    function automatic logic taken(input logic [2:0] f3, input logic z);
        case (f3)
            3'd0, 3'd5, 3'd7: taken = z;
            default: taken = !z;
        endcase
    endfunction
    task automatic gen(input logic [31:0] ins, input logic z);
        logic [6:0] op;
        logic [2:0] f3;
        op = ins[6:0];
        f3 = ins[14:12];
        cur_imm = imm_of(op);
        q.push_back(mk(1, 0, 0, 1, 2, 0, 2, 0, ADD, 0));
        q.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, ADD, 0));
        case (op)
            7'b0000011: begin
                q.push_back(mk(0, 0, 0, 0, 0, 2, 1, 0, ADD, 0));
                q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, ADD, 0));
                q.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, ADD, 1));
            end
            7'b0100011: begin
                q.push_back(mk(0, 0, 0, 0, 0, 2, 1, 0, ADD, 0));
                q.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, ADD, 1));
            end
            7'b0110011, 7'b0010011: begin
                logic r;
                r = op == 7'b0110011;
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    q.push_back(mk(0, 0, 0, 0, 0, 2, r ? 0 : 1, 0, ADD, 0));
                    m_ill = 1'b1;
                end else begin
                    q.push_back(mk(0, 0, 0, 0, 0, 2, r ? 0 : 1, 0,
                                   (r && f3 == 3'd0 && ins[30]) ? SUB : alu_of(f3), 0));
                    q.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, ADD, 1));
                end
            end
            7'b1100011: begin
                if (f3 == 3'd2 || f3 == 3'd3) begin
                    q.push_back(mk(0, 0, 0, 0, 0, 2, 0, 0, SUB, 0));
                    m_ill = 1'b1;
                end else
                    q.push_back(mk(taken(f3, z), 0, 0, 0, 0, 2, 0, 0,
                                   f3 >= 3'd6 ? SLTU : f3 >= 3'd4 ? SLT : SUB, 1));
            end
            7'b1101111: begin
                q.push_back(mk(1, 0, 0, 0, 0, 1, 2, 0, ADD, 0));
                q.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, ADD, 1));
            end
            7'b1100111: begin
                q.push_back(mk(0, 0, 0, 0, 0, 2, 1, 0, ADD, 0));
                q.push_back(mk(1, 0, 0, 0, 0, 1, 2, 0, ADD, 0));
                q.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, ADD, 1));
            end
`ifdef UTYPE_INSTR_EN
            7'b0110111, 7'b0010111: begin
                logic au;
                au = op == 7'b0010111;
                q.push_back(mk(0, 0, 0, 0, 0, au ? 1 : 0, 1, 0, au ? ADD : PASS, 0));
                q.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, ADD, 1));
            end
`endif
            default: m_ill = 1'b1;
        endcase
    endtask
    task automatic run(input string nm, input logic [31:0] ins, input logic z);
        cur_name = nm;
        bus.Op = ins[6:0];
        bus.Funct3 = ins[14:12];
        bus.Funct7 = ins[31:25];
        bus.Zero = z;
        obs.delete();
        gen(ins, z);
        while (q.size() > 0) @(posedge clk);
        #1;
    endtask
    initial begin
        bus.Op = 7'h13;
        bus.Funct3 = 3'd0;
        bus.Funct7 = 7'd0;
        bus.Zero = 1'b0;
        @(negedge clk);
        chk("reset_strobes", {bus.PCWrite, bus.RegWrite, bus.MemWrite, bus.IRWrite, bus.Instr_Done}, 0);
        chk("reset_illegal", bus.Illegal_o, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        run("addi", 32'h00500093, 0);
        chk("addi_rw_c3", obs[2].rw, 0);
        chk("addi_rw_c4", obs[3].rw, 1);
        chk("addi_done_c4", obs[3].done, 1);
        chk("addi_alu_c3", obs[2].aluc, 0);
        run("lw", 32'h0000A103, 0);
        chk("lw_adrsrc_memread", obs[3].adr, 1);
        chk("lw_wb", {obs[4].rw, obs[4].rsrc}, 3'b101);
        run("sw", 32'h0020A223, 0);
        run("sub", 32'h402081B3, 0);
        chk("sub_alu", obs[2].aluc, 1);
        run("xor", 32'h0020C1B3, 0);
        run("ori", 32'h0050E093, 0);
        run("bne_z0", 32'h00209463, 0);
        chk("bne_z0_pcw", obs[2].pcw, 1);
        chk("bne_alu", obs[2].aluc, 1);
        run("bne_z1", 32'h00209463, 1);
        chk("bne_z1_pcw", obs[2].pcw, 0);
        run("blt_z0", 32'h0020C463, 0);
        run("bgeu_z1", 32'h0020F463, 1);
        run("jal", 32'h008000EF, 0);
        run("jalr", 32'h000080E7, 0);
        run("op7f", 32'h0000007F, 0);
        chk("op7f_illegal", bus.Illegal_o, 1);
        run("slli", 32'h00209093, 0);
        chk("slli_no_rw", obs[2].rw, 0);
        chk("slli_back_fetch", bus.IRWrite, 1);
        run("bad_branch", 32'h0020A463, 0);
        run("addi_sticky", 32'h00500093, 0);
        chk("illegal_sticky", obs[0].ill, 1);
        cur_name = "sw_reset";
        bus.Op = 7'b0100011;
        bus.Funct3 = 3'b010;
        obs.delete();
        gen(32'h0020A223, 0);
        repeat (4) @(negedge clk);
        #1;
        chk("memwrite_before_reset", bus.MemWrite, 1);
        reset = 1'b1;
        #1;
        chk("reset_memwrite_drop", bus.MemWrite, 0);
        chk("reset_illegal_clear", bus.Illegal_o, 0);
        chk("reset_no_strobes", {bus.PCWrite, bus.RegWrite, bus.IRWrite, bus.Instr_Done}, 0);
        @(posedge clk);
        #1;
        chk("reset_hold_strobes", {bus.PCWrite, bus.RegWrite, bus.MemWrite, bus.IRWrite}, 0);
        reset = 1'b0;
        m_ill = 1'b0;
        run("addi_after_reset", 32'h00500093, 0);
        chk("after_reset_fetch_irw", obs[0].irw, 1);
        run("lui", 32'h123450B7, 0);
`ifdef UTYPE_INSTR_EN
        chk("lui_rw", obs[3].rw, 1);
        chk("lui_alu", obs[2].aluc, 7);
        chk("lui_legal", bus.Illegal_o, 0);
`else
        chk("lui_illegal", bus.Illegal_o, 1);
`endif
        run("auipc", 32'h00000097, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
